// File: rtl/alu16_seq_if.sv
// Request/response bundle between the instruction decoder and alu16_seq.
// The decoder drives the master side; the sequencer implements the slave side.
interface alu16_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [7:0]  flagsIn;
    logic [1:0]  tagIn;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flagsOut;
    logic [1:0]  tagOut;

    modport master (
        output start, op, opA, opB, flagsIn, tagIn,
        input  busy, done, result, flagsOut, tagOut
    );

    modport slave (
        input  start, op, opA, opB, flagsIn, tagIn,
        output busy, done, result, flagsOut, tagOut
    );
endinterface

// File: rtl/alu16_seq.sv
// SM83 16-bit add sequencer: drives the shared 8-bit ALU low byte, then high byte.
// Optional INC16/DEC16 on op=3 is enabled by defining ALU16_INCDEC_EN.
module alu16_seq #(
    parameter logic [4:0] OPC_ADD = 5'b00000,
    parameter logic [4:0] OPC_ADC = 5'b00001
) (
    input  logic        clk,
    input  logic        rst_n,
    alu16_seq_if.slave  bus,
    output logic [7:0]  aluA,
    output logic [7:0]  aluB,
    output logic [4:0]  aluOp,
    output logic        aluCarryIn,
    input  logic [7:0]  aluRes,
    input  logic [7:0]  aluFlags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  opr;
    logic [7:0]  flg;
    logic [1:0]  tag;
    logic [7:0]  ahi;
    logic [7:0]  bhi;
    logic [7:0]  resLo;
    logic        hLo;
    logic        cLo;
    logic        legal;
    logic        is_sp;
    logic [7:0]  merged;

    logic        busy_q;
    logic        done_q;
    logic [15:0] result_q;
    logic [7:0]  flags_q;
    logic [1:0]  tag_q;

`ifdef ALU16_INCDEC_EN
    assign legal = 1'b1;
`else
    assign legal = (bus.op != 2'd3);
`endif

    assign is_sp = (opr == 2'd1) || (opr == 2'd2);

    // High-byte flags only matter for ADD16; SP forms report the low-byte carries.
    always_comb begin
        merged = 8'h00;
        unique case (1'b1)
            (opr == 2'd0): merged = {flg[7], 1'b0, aluFlags[5], aluFlags[4], 4'h0};
            is_sp:         merged = {2'b00, hLo, cLo, 4'h0};
            default:       merged = flg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opr        <= 2'd0;
            flg        <= 8'h00;
            tag        <= 2'd0;
            ahi        <= 8'h00;
            bhi        <= 8'h00;
            resLo      <= 8'h00;
            hLo        <= 1'b0;
            cLo        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 16'h0000;
            flags_q    <= 8'h00;
            tag_q      <= 2'd0;
            aluA       <= 8'h00;
            aluB       <= 8'h00;
            aluOp      <= OPC_ADD;
            aluCarryIn <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && legal) begin
                        state      <= LOW;
                        busy_q     <= 1'b1;
                        opr        <= bus.op;
                        flg        <= bus.flagsIn;
                        tag        <= bus.tagIn;
                        ahi        <= bus.opA[15:8];
                        bhi        <= (bus.op == 2'd1 || bus.op == 2'd2)
                                      ? {8{bus.opB[7]}} : bus.opB[15:8];
                        aluA       <= bus.opA[7:0];
                        aluB       <= bus.opB[7:0];
                        aluOp      <= OPC_ADD;
                        aluCarryIn <= 1'b0;
                    end
                end
                LOW: begin
                    state      <= HIGH;
                    resLo      <= aluRes;
                    hLo        <= aluFlags[5];
                    cLo        <= aluFlags[4];
                    aluA       <= ahi;
                    aluB       <= bhi;
                    aluOp      <= OPC_ADC;
                    aluCarryIn <= aluFlags[4];
                end
                HIGH: begin
                    state      <= DONE;
                    done_q     <= 1'b1;
                    result_q   <= {aluRes, resLo};
                    flags_q    <= merged;
                    tag_q      <= tag;
                    aluA       <= 8'h00;
                    aluB       <= 8'h00;
                    aluOp      <= OPC_ADD;
                    aluCarryIn <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.flagsOut = flags_q;
    assign bus.tagOut   = tag_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural 8-bit ALU attached.
// Expected values are hand-computed constants.
module tb_alu16_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [4:0] aluOp;
    logic       aluCarryIn;
    logic [7:0] aluRes;
    logic [7:0] aluFlags;

    int total = 0;
    int bad   = 0;
    int dones = 0;

    alu16_seq_if bus ();

    alu16_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluOp      (aluOp),
        .aluCarryIn (aluCarryIn),
        .aluRes     (aluRes),
        .aluFlags   (aluFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit ALU: ADD and ADC, Z/H/C flags, N cleared.
    logic [8:0] sum;
    logic [4:0] nib;
    logic       cin;
    always_comb begin
        cin      = (aluOp == 5'b00001) ? aluCarryIn : 1'b0;
        sum      = {1'b0, aluA} + {1'b0, aluB} + {8'h00, cin};
        nib      = {1'b0, aluA[3:0]} + {1'b0, aluB[3:0]} + {4'h0, cin};
        aluRes   = sum[7:0];
        aluFlags = {(sum[7:0] == 8'h00), 1'b0, nib[4], sum[8], 4'h0};
    end

    always @(posedge clk) if (bus.done) dones <= dones + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] f,
                         input logic [1:0] t);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.opA     = a;
        bus.opB     = b;
        bus.flagsIn = f;
        bus.tagIn   = t;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.opA     = 16'h0000;
        bus.opB     = 16'h0000;
        bus.flagsIn = 8'h00;
        bus.tagIn   = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_result", {16'd0, bus.result}, 32'h0);
        chk("rst_flags",  {24'd0, bus.flagsOut}, 32'h0);
        chk("rst_alu",    {11'd0, aluA, aluB, aluOp}, 32'h0);
        rst_n = 1'b1;

        // ADD16 0x0FFF + 0x0001, Z preserved
        issue(2'd0, 16'h0FFF, 16'h0001, 8'h80, 2'd1);
        @(negedge clk);
        chk("a1_low_busy", {31'd0, bus.busy}, 32'd1);
        chk("a1_low_alu",  {11'd0, aluA, aluB, aluOp}, {11'd0, 8'hFF, 8'h01, 5'd0});
        @(negedge clk);
        chk("a1_high_alu", {10'd0, aluA, aluB, aluOp, aluCarryIn},
            {10'd0, 8'h0F, 8'h00, 5'd1, 1'b1});
        chk("a1_high_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        chk("a1_done",   {30'd0, bus.done, bus.busy}, 32'd3);
        chk("a1_result", {16'd0, bus.result}, 32'h1000);
        chk("a1_flags",  {24'd0, bus.flagsOut}, 32'hA0);
        chk("a1_tag",    {30'd0, bus.tagOut}, 32'd1);
        @(negedge clk);
        chk("a1_after",  {30'd0, bus.done, bus.busy}, 32'd0);
        chk("a1_hold",   {16'd0, bus.result}, 32'h1000);
        chk("a1_aluidle", {10'd0, aluA, aluB, aluOp, aluCarryIn}, 32'h0);

        // ADD16 wrap to zero; Z stays clear
        issue(2'd0, 16'hFFFF, 16'h0001, 8'h00, 2'd0);
        repeat (3) @(negedge clk);
        chk("a2_result", {16'd0, bus.result}, 32'h0000);
        chk("a2_flags",  {24'd0, bus.flagsOut}, 32'h30);

        // ADD16 no carries, Z preserved from F=0xF0
        issue(2'd0, 16'h1234, 16'h1111, 8'hF0, 2'd3);
        repeat (3) @(negedge clk);
        chk("a3_result", {16'd0, bus.result}, 32'h2345);
        chk("a3_flags",  {24'd0, bus.flagsOut}, 32'h80);
        chk("a3_tag",    {30'd0, bus.tagOut}, 32'd3);

        // ADDSP 0xFFF8 + 8
        issue(2'd1, 16'hFFF8, 16'h0008, 8'hF0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("sp_high_alu", {10'd0, aluA, aluB, aluOp, aluCarryIn},
            {10'd0, 8'hFF, 8'h00, 5'd1, 1'b1});
        @(negedge clk);
        chk("sp_result", {16'd0, bus.result}, 32'h0000);
        chk("sp_flags",  {24'd0, bus.flagsOut}, 32'h30);

        // LDHLSP 0x0005 + (-2), opB[15:8] ignored
        issue(2'd2, 16'h0005, 16'hAAFE, 8'h00, 2'd2);
        @(negedge clk);
        @(negedge clk);
        chk("ld_high_aluB", {24'd0, aluB}, 32'hFF);
        chk("ld_high_cin",  {31'd0, aluCarryIn}, 32'd1);
        @(negedge clk);
        chk("ld_result", {16'd0, bus.result}, 32'h0003);
        chk("ld_flags",  {24'd0, bus.flagsOut}, 32'h30);
        chk("ld_tag",    {30'd0, bus.tagOut}, 32'd2);

        // start during LOW is ignored
        @(negedge clk);
        dones = 0;
        issue(2'd0, 16'h0100, 16'h0200, 8'h00, 2'd1);
        bus.start = 1'b1;
        bus.opA   = 16'h7777;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ign_dones",  dones, 32'd1);
        chk("ign_result", {16'd0, bus.result}, 32'h0300);

        // reset during HIGH aborts
        dones = 0;
        issue(2'd0, 16'h1111, 16'h2222, 8'h80, 2'd2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
        chk("abort_result", {16'd0, bus.result}, 32'h0000);
        chk("abort_alu",    {10'd0, aluA, aluB, aluOp, aluCarryIn}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_dones",  dones, 32'd0);
        chk("abort_hold",   {16'd0, bus.result}, 32'h0000);

        // op=3: INC/DEC when enabled, rejected otherwise
        issue(2'd0, 16'h0042, 16'h0001, 8'h00, 2'd1);
        repeat (3) @(negedge clk);
        chk("pre3_result", {16'd0, bus.result}, 32'h0043);
        @(negedge clk);
        dones = 0;
        issue(2'd3, 16'h1234, 16'hFFFF, 8'h50, 2'd2);
`ifdef ALU16_INCDEC_EN
        @(negedge clk);
        chk("op3_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("op3_done",   {31'd0, bus.done}, 32'd1);
        chk("op3_result", {16'd0, bus.result}, 32'h1233);
        chk("op3_flags",  {24'd0, bus.flagsOut}, 32'h50);
        chk("op3_tag",    {30'd0, bus.tagOut}, 32'd2);
`else
        @(negedge clk);
        chk("op3_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk("op3_dones",  dones, 32'd0);
        chk("op3_result", {16'd0, bus.result}, 32'h0043);
        chk("op3_flags",  {24'd0, bus.flagsOut}, 32'h00);
        chk("op3_tag",    {30'd0, bus.tagOut}, 32'd1);
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
